// File: rtl/conv1_frame_ctrl_pkg.sv
// Shared types and constants for the conv1 frame sequencer.
package conv1_frame_ctrl_pkg;

  localparam int unsigned IMG_H_DEF = 28;
  localparam int unsigned IMG_W_DEF = 28;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // Number of valid 3x3 windows in an h x w frame.
  function automatic int unsigned exp_results(input int unsigned h, input int unsigned w);
    return (h - 2) * (w - 2);
  endfunction

  localparam int unsigned EXP_CNT_DEF = exp_results(IMG_H_DEF, IMG_W_DEF);

endpackage

// File: rtl/conv1_frame_ctrl_if.sv
// Frame-buffer / engine / host bundle of the conv1 frame sequencer.
interface conv1_frame_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 10
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     in_en;
  logic [ADDR_W-1:0]        in_addr;
  logic signed [DATA_W-1:0] in_rdata;
  logic                     conv_rst_n;
  logic signed [DATA_W-1:0] conv_data_in;
  logic                     conv_rdata_r;
  logic signed [ACC_W-1:0]  conv_data_out;
  logic                     conv_wdata_r;
  logic                     out_we;
  logic [ADDR_W-1:0]        out_addr;
  logic signed [ACC_W-1:0]  out_wdata;

  modport master (
    input  start, in_rdata, conv_data_out, conv_wdata_r,
    output busy, done, err, in_en, in_addr, conv_rst_n, conv_data_in,
           conv_rdata_r, out_we, out_addr, out_wdata
  );

  modport slave (
    output start, in_rdata, conv_data_out, conv_wdata_r,
    input  busy, done, err, in_en, in_addr, conv_rst_n, conv_data_in,
           conv_rdata_r, out_we, out_addr, out_wdata
  );
endinterface

// File: rtl/conv1_frame_ctrl_delay_line.sv
// Fixed-depth register delay line with asynchronous active-low reset.
module conv_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH*DEPTH-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= i_d;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= {r_pipe[WIDTH*(DEPTH-1)-1:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_pipe[WIDTH*DEPTH-1 -: WIDTH];
endmodule

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer: streams one frame column-major into the conv1 engine and
// writes every engine result to the output SRAM at sequential addresses.
module conv1_frame_ctrl
  import conv1_frame_ctrl_pkg::*;
#(
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PIPE_LAT = 1
) (
  input logic                clk,
  input logic                reset_n,
  conv1_frame_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(IMG_H * IMG_W - 1);
  localparam logic [ADDR_W-1:0] EXP_CNT    = ADDR_W'(exp_results(IMG_H, IMG_W));
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(PIPE_LAT + 1);

  state_e                   r_state;
  logic                     r_busy, r_done, r_err;
  logic                     r_in_en, r_conv_rst_n, r_conv_rdata_r, r_out_we;
  logic [ADDR_W-1:0]        r_in_addr, r_out_addr, r_pix, r_cnt, r_drain;
  logic signed [ACC_W-1:0]  r_out_wdata;
  logic signed [DATA_W-1:0] w_pix;
  logic                     w_strb, w_strb_d, w_cap, w_ovf;
  logic [ADDR_W-1:0]        w_cnt_nxt;

  assign w_strb = bus.conv_wdata_r & r_conv_rst_n;

  conv_delay_line #(.WIDTH(1), .DEPTH(PIPE_LAT)) u_strb_dly (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (w_strb),
    .o_q   (w_strb_d)
  );

  // A delayed strobe beyond the expected count is dropped and flagged.
  always_comb begin
    w_cap = 1'b0;
    w_ovf = 1'b0;
    if (w_strb_d) begin
      if (r_cnt == EXP_CNT) w_ovf = 1'b1;
      else                  w_cap = 1'b1;
    end
    w_cnt_nxt = r_cnt + ADDR_W'(w_cap);
  end

  assign w_pix = (r_state == STREAM) ? bus.in_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_in_en        <= 1'b0;
      r_conv_rst_n   <= 1'b0;
      r_conv_rdata_r <= 1'b0;
      r_out_we       <= 1'b0;
      r_in_addr      <= '0;
      r_out_addr     <= '0;
      r_out_wdata    <= '0;
      r_pix          <= '0;
      r_cnt          <= '0;
      r_drain        <= '0;
    end else begin
      r_done   <= 1'b0;
      r_out_we <= w_cap;
      if (w_cap) begin
        r_out_addr  <= r_cnt;
        r_out_wdata <= bus.conv_data_out;
      end
      r_cnt <= w_cnt_nxt;
      if (w_ovf) r_err <= 1'b1;

      unique case (r_state)
        IDLE: if (bus.start) begin
          r_state   <= PREFETCH;
          r_busy    <= 1'b1;
          r_err     <= 1'b0;
          r_cnt     <= '0;
          r_in_en   <= 1'b1;
          r_in_addr <= '0;
        end
        PREFETCH: begin
          r_state        <= STREAM;
          r_conv_rst_n   <= 1'b1;
          r_conv_rdata_r <= 1'b1;
          r_pix          <= '0;
          r_in_en        <= 1'b1;
          r_in_addr      <= ADDR_W'(1);
        end
        STREAM: begin
          // Read address runs one pixel ahead of the pixel on conv_data_in.
          r_in_en <= (r_pix < LAST_PIX - ADDR_W'(1));
          if (r_pix < LAST_PIX - ADDR_W'(1)) r_in_addr <= r_in_addr + ADDR_W'(1);
          if (r_pix == LAST_PIX) begin
            r_state        <= DRAIN;
            r_conv_rdata_r <= 1'b0;
            r_drain        <= '0;
          end else begin
            r_pix <= r_pix + ADDR_W'(1);
          end
        end
        DRAIN: begin
          r_drain <= r_drain + ADDR_W'(1);
          if (r_cnt == EXP_CNT || r_drain == DRAIN_LAST) begin
            r_state      <= DONE;
            r_done       <= 1'b1;
            r_conv_rst_n <= 1'b0;
            r_err        <= r_err | w_ovf | (w_cnt_nxt != EXP_CNT);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.in_en        = r_in_en;
  assign bus.in_addr      = r_in_addr;
  assign bus.conv_rst_n   = r_conv_rst_n;
  assign bus.conv_data_in = w_pix;
  assign bus.conv_rdata_r = r_conv_rdata_r;
  assign bus.out_we       = r_out_we;
  assign bus.out_addr     = r_out_addr;
  assign bus.out_wdata    = r_out_wdata;
endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Directed bench for conv1_frame_ctrl with behavioural SRAM and 3x3 engine models.
`timescale 1ns/1ps
module tb_conv1_frame_ctrl;
  localparam int H      = 28;
  localparam int NPIX   = 784;
  localparam int NWIN   = 676;
  localparam int BIAS   = -58730196;
  localparam int W_EDGE = 330;
  localparam int W_CTR  = 333;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  conv1_frame_ctrl_if #(.DATA_W(16), .ACC_W(32), .ADDR_W(10)) bus ();

  conv1_frame_ctrl #(
    .IMG_H(28), .IMG_W(28), .DATA_W(16), .ACC_W(32), .ADDR_W(10), .PIPE_LAT(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic signed [15:0] img     [NPIX];
  logic signed [15:0] eng_buf [NPIX];
  int eng_k = 0;
  int eng_w = 0;
  int drop_idx = -1;
  logic signed [31:0] eng_pend = '0;

  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  int done_n = 0;

  // Input SRAM: one-cycle read latency.
  always @(posedge clk) if (bus.in_en === 1'b1) bus.in_rdata <= img[bus.in_addr];

  function automatic int eng_sum(input int k, input logic signed [15:0] px);
    int s, r, c, idx;
    r = k % H;
    c = k / H;
    s = BIAS;
    for (int dc = 0; dc < 3; dc++)
      for (int dr = 0; dr < 3; dr++) begin
        idx = (c - dc) * H + (r - dr);
        s += ((idx == k) ? int'(px) : int'(eng_buf[idx])) * ((dr == 1 && dc == 1) ? W_CTR : W_EDGE);
      end
    return s;
  endfunction

  // Engine: strobe one cycle after the window's last pixel, data one cycle later.
  always @(posedge clk) begin
    if (bus.conv_rst_n !== 1'b1) begin
      eng_k             <= 0;
      eng_w             <= 0;
      eng_pend          <= '0;
      bus.conv_wdata_r  <= 1'b0;
      bus.conv_data_out <= '0;
    end else begin
      bus.conv_data_out <= eng_pend;
      bus.conv_wdata_r  <= 1'b0;
      if (bus.conv_rdata_r === 1'b1 && eng_k < NPIX) begin
        eng_buf[eng_k] <= bus.conv_data_in;
        eng_k          <= eng_k + 1;
        if ((eng_k % H) >= 2 && (eng_k / H) >= 2) begin
          eng_pend         <= eng_sum(eng_k, bus.conv_data_in);
          bus.conv_wdata_r <= (eng_w != drop_idx);
          eng_w            <= eng_w + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bus.in_en === 1'b1) rd_q.push_back(int'(bus.in_addr));
    if (bus.out_we === 1'b1) begin
      wa_q.push_back(int'(bus.out_addr));
      wd_q.push_back(int'(bus.out_wdata));
    end
    if (bus.done === 1'b1) done_n++;
  end

  function automatic int ref_win(input int w);
    int r, c, s;
    r = 2 + w % 26;
    c = 2 + w / 26;
    s = BIAS;
    for (int dc = 0; dc < 3; dc++)
      for (int dr = 0; dr < 3; dr++)
        s += int'(img[(c - dc) * H + (r - dr)]) * ((dr == 1 && dc == 1) ? W_CTR : W_EDGE);
    return s;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_busy"},         bus.busy, 0);
    check({p, "_done"},         bus.done, 0);
    check({p, "_err"},          bus.err, 0);
    check({p, "_in_en"},        bus.in_en, 0);
    check({p, "_conv_rdata_r"}, bus.conv_rdata_r, 0);
    check({p, "_out_we"},       bus.out_we, 0);
    check({p, "_in_addr"},      bus.in_addr, 0);
    check({p, "_out_addr"},     bus.out_addr, 0);
    check({p, "_out_wdata"},    bus.out_wdata, 0);
    check({p, "_conv_data_in"}, bus.conv_data_in, 0);
    check({p, "_conv_rst_n"},   bus.conv_rst_n, 0);
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (bus.done !== 1'b1 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done_seen"}, bus.done, 1);
  endtask

  task automatic check_frame(input string tag, input int rb, input int wb, input int db,
                             input int exp_wr, input bit exp_err, input int drop, input int first_exp);
    int nrd, nwr, bad, w;
    nrd = rd_q.size() - rb;
    check({tag, "_rd_count"}, nrd, NPIX);
    bad = 0;
    for (int i = 0; i < nrd && i < NPIX; i++) if (rd_q[rb + i] != i) bad++;
    check({tag, "_rd_order_bad"}, bad, 0);
    nwr = wa_q.size() - wb;
    check({tag, "_wr_count"}, nwr, exp_wr);
    bad = 0;
    for (int i = 0; i < nwr; i++) begin
      w = (drop >= 0 && i >= drop) ? i + 1 : i;
      if (wa_q[wb + i] != i || w >= NWIN || wd_q[wb + i] != ref_win(w)) bad++;
    end
    check({tag, "_wr_content_bad"}, bad, 0);
    if (nwr > 0) check({tag, "_first_data"}, wd_q[wb], first_exp);
    check({tag, "_done_pulses"}, done_n - db, 1);
    check({tag, "_err"}, bus.err, exp_err);
  endtask

  task automatic do_frame(input string tag, input int exp_wr, input bit exp_err, input int drop,
                          input int first_exp, input bit start_now, input bit mid_start, input bit done_start);
    int rb, wb, db;
    rb = rd_q.size();
    wb = wa_q.size();
    db = done_n;
    if (!start_now) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_on_accept"}, bus.busy, 1);
    check({tag, "_err_cleared"}, bus.err, 0);
    if (mid_start) begin
      repeat (200) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_done(tag);
    check_frame(tag, rb, wb, db, exp_wr, exp_err, drop, first_exp);
    if (done_start) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_after_done"}, bus.busy, 0);
    check({tag, "_done_one_cycle"}, bus.done, 0);
  endtask

  initial begin
    int db, i;
    bus.start = 1'b0;
    for (int k = 0; k < NPIX; k++) img[k] = 16'sd1;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("in_reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("after_release");
    check("no_sram_reads", rd_q.size(), 0);
    check("no_sram_writes", wa_q.size(), 0);

    do_frame("ones", NWIN, 1'b0, -1, -58727223, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < NPIX; k++) img[k] = '0;
    do_frame("zeros", NWIN, 1'b0, -1, -58730196, 1'b1, 1'b1, 1'b1);
    db = done_n;
    repeat (5) @(negedge clk);
    check("done_start_ignored_busy", bus.busy, 0);
    check("done_start_ignored_done", done_n - db, 0);

    for (int k = 0; k < NPIX; k++) img[k] = 16'(((k * 37) % 61) - 30);
    db = done_n;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    i = 0;
    while (!(bus.in_en === 1'b1 && bus.in_addr == 10'd300) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("abort_reached_px300", bus.in_addr, 300);
    reset_n = 1'b0;
    #1;
    check_reset("abort");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_n - db, 0);
    check("abort_idle_busy", bus.busy, 0);

    do_frame("pattern", NWIN, 1'b0, -1, ref_win(0), 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < NPIX; k++) img[k] = 16'sd1;
    drop_idx = 100;
    do_frame("drop", NWIN - 1, 1'b1, 100, -58727223, 1'b0, 1'b0, 1'b0);
    drop_idx = -1;
    repeat (10) @(negedge clk);
    check("err_sticky", bus.err, 1);

    do_frame("after_drop", NWIN, 1'b0, -1, -58727223, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
